// File: rtl/tt_um_div_4bits.sv
// tt_um_div_4bits: sequential unsigned restoring divider.
// Accepts Dividend/Divisor on a start pulse, resolves one quotient bit per
// clock and publishes Quotient/Remainder together with a one-cycle done.
// Optional feature macro: DIV_ZERO_DETECT_EN (divide-by-zero short cut and
// div_by_zero flag). With the macro undefined, a zero divisor simply runs the
// full iteration count and div_by_zero is tied low.
//
// Handshake: start is a request that is only sampled while the FSM is in
// IDLE or DONE; while busy=1 it is ignored and operands are not re-captured.
// done pulses for exactly one cycle per accepted operation and is never high
// together with busy. A start in the DONE cycle is accepted back-to-back.
module tt_um_div_4bits #(
    parameter int bits = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [bits-1:0] Dividend,
    input  logic [bits-1:0] Divisor,
    output logic [bits-1:0] Quotient,
    output logic [bits-1:0] Remainder,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [1:0]      dbg_state_o
);

    localparam int CW = $clog2(bits + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [bits-1:0] div_q;       // captured divisor
    logic [bits-1:0] quo_q;       // working quotient, starts as the dividend
    logic [bits:0]   rem_q;       // partial remainder incl. borrow bit
    logic [bits-1:0] quot_out_q;
    logic [bits-1:0] rem_out_q;
    logic            busy_q;
    logic            done_q;

    logic [bits:0]   shifted_d;
    logic [bits:0]   trial_d;
    logic [bits:0]   rem_d;
    logic [bits-1:0] quo_d;

    // One restoring step: shift {rem, quo} left, try subtracting the divisor,
    // keep the difference only when it did not borrow.
    always_comb begin
        shifted_d = {rem_q[bits-1:0], quo_q[bits-1]};
        trial_d   = shifted_d - {1'b0, div_q};
        rem_d     = shifted_d;
        quo_d     = {quo_q[bits-2:0], 1'b0};
        if (!trial_d[bits]) begin
            rem_d    = trial_d;
            quo_d[0] = 1'b1;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic dbz_q;
`endif

    // Control FSM, working registers and registered results in one process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        div_q <= Divisor;
                        quo_q <= Dividend;
                        rem_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
                        if (Divisor == '0) begin
                            // Zero divisor: publish the natural restoring
                            // result at once without entering RUN.
                            state_q    <= S_DONE;
                            cnt_q      <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            quot_out_q <= '1;
                            rem_out_q  <= Dividend;
                            dbz_q      <= 1'b1;
                        end else
`endif
                        begin
                            state_q <= S_RUN;
                            cnt_q   <= CW'(bits);
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        // Last iteration: results become visible only here.
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        quot_out_q <= quo_d;
                        rem_out_q  <= rem_d[bits-1:0];
`ifdef DIV_ZERO_DETECT_EN
                        dbz_q      <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Quotient    = quot_out_q;
    assign Remainder   = rem_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;
`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_div_4bits.sv
// Testbench for tt_um_div_4bits: table vectors, random operands against an
// arithmetic reference, exhaustive sweep and protocol sequences.
module tb_tt_um_div_4bits;

    localparam int BITS = 4;
    localparam int MAXV = (1 << BITS) - 1;
`ifdef DIV_ZERO_DETECT_EN
    localparam int ZLAT = 0;
    localparam int ZDBZ = 1;
`else
    localparam int ZLAT = BITS;
    localparam int ZDBZ = 0;
`endif

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [BITS-1:0] Dividend;
    logic [BITS-1:0] Divisor;
    logic [BITS-1:0] Quotient;
    logic [BITS-1:0] Remainder;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [1:0]      dbg_state;

    int n_vec = 0;
    int n_err = 0;

    tt_um_div_4bits #(.bits(BITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
        int lat;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? MAXV : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_lat(input int b);
        return (b == 0) ? ZLAT : BITS;
    endfunction

    // Driver: one start pulse, bounded wait for done, protocol checks.
    task automatic do_op(input int a, input int b, input int exp_lat,
                         output int q, output int r, output int dbz);
        int lat;
        @(negedge clk);
        start    = 1'b1;
        Dividend = BITS'(a);
        Divisor  = BITS'(b);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", int'(busy), (exp_lat > 0) ? 1 : 0);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("busy_with_done", int'(busy), 0);
        q   = int'(Quotient);
        r   = int'(Remainder);
        dbz = int'(div_by_zero);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_quotient"}, int'(Quotient), 0);
        check({tag, "_remainder"}, int'(Remainder), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_div_by_zero"}, int'(div_by_zero), 0);
    endtask

    initial begin
        int q, r, dbz, lat, seen, a, b;

        tbl[0] = '{13, 4, 3, 1, 0, BITS};
        tbl[1] = '{15, 1, 15, 0, 0, BITS};
        tbl[2] = '{0, 7, 0, 0, 0, BITS};
        tbl[3] = '{3, 9, 0, 3, 0, BITS};
        tbl[4] = '{9, 0, 15, 9, ZDBZ, ZLAT};
        tbl[5] = '{15, 15, 1, 0, 0, BITS};
        tbl[6] = '{14, 15, 0, 14, 0, BITS};
        tbl[7] = '{15, 2, 7, 1, 0, BITS};

        // Reset
        rst_n    = 1'b0;
        start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].lat, q, r, dbz);
            check("tbl_quotient", q, tbl[i].q);
            check("tbl_remainder", r, tbl[i].r);
            check("tbl_div_by_zero", dbz, tbl[i].dbz);
        end

        // Random operands against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, MAXV));
            b = int'($urandom_range(0, MAXV));
            do_op(a, b, ref_lat(b), q, r, dbz);
            check("rnd_quotient", q, ref_q(a, b));
            check("rnd_remainder", r, ref_r(a, b));
            check("rnd_div_by_zero", dbz, (b == 0) ? ZDBZ : 0);
        end

        // Exhaustive sweep of the division identity
        for (int ia = 0; ia <= MAXV; ia++) begin
            for (int ib = 0; ib <= MAXV; ib++) begin
                do_op(ia, ib, ref_lat(ib), q, r, dbz);
                if (ib != 0) begin
                    check("sweep_identity", q * ib + r, ia);
                    check("sweep_rem_lt_div", (r < ib) ? 1 : 0, 1);
                end else begin
                    check("sweep_zero_quotient", q, MAXV);
                    check("sweep_zero_remainder", r, ia);
                end
            end
        end

        // start held high through RUN with changing operands, then a
        // back-to-back operation accepted in the DONE cycle
        @(negedge clk);
        start    = 1'b1;
        Dividend = 4'd13;
        Divisor  = 4'd4;
        @(negedge clk);
        lat = 0;
        while (!done && lat < 20) begin
            Dividend = BITS'($urandom_range(0, MAXV));
            Divisor  = BITS'($urandom_range(1, MAXV));
            @(negedge clk);
            lat++;
        end
        check("held_latency", lat, BITS);
        check("held_quotient", int'(Quotient), 3);
        check("held_remainder", int'(Remainder), 1);
        Dividend = 4'd11;
        Divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_dropped", int'(done), 0);
        check("b2b_busy", int'(busy), 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_latency", lat, BITS);
        check("b2b_quotient", int'(Quotient), 3);
        check("b2b_remainder", int'(Remainder), 2);
        @(negedge clk);

        // Known nonzero result, then abort at iteration 2 with reset
        do_op(13, 4, BITS, q, r, dbz);
        @(negedge clk);
        start    = 1'b1;
        Dividend = 4'd14;
        Divisor  = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_quotient_held", int'(Quotient), 0);

        // Recovery after abort
        do_op(13, 4, BITS, q, r, dbz);
        check("recover_quotient", q, 3);
        check("recover_remainder", r, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
